// File: rtl/tx_serializer_10b.sv
// 10-bit symbol serializer: one-entry holding register feeding an MSB-first shifter.
// Optional idle comma fill (K28.5) is built when COMMA_IDLE_FILL_EN is defined.
module tx_serializer_10b #(
  parameter int SYMBOL_W = 10
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  input  logic [SYMBOL_W-1:0] symbol_i,
  input  logic                symbol_valid_i,
  output logic                symbol_ready_o,
  input  logic                rd_neg_i,
  output logic                serial_o,
  output logic                serial_valid_o,
  output logic                symbol_start_o,
  output logic [7:0]          fill_count_o
);

  localparam logic [3:0] LAST_BIT = 4'(SYMBOL_W - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t              r_state;
  logic [SYMBOL_W-1:0] r_shift;
  logic [3:0]          r_cnt;
  logic [SYMBOL_W-1:0] r_hold;
  logic                r_hold_full;

  logic w_accept;
  logic w_boundary;
  logic w_load;
  logic w_fill;

  // Reset is folded into ready so nothing is accepted while the block is held.
  assign symbol_ready_o = enable_i & ~r_hold_full & ~rst_i;
  assign w_accept       = symbol_valid_i & symbol_ready_o;
  assign w_boundary     = (r_state == ST_IDLE) | (r_cnt == LAST_BIT);
  assign w_load         = w_boundary & enable_i & r_hold_full;

`ifdef COMMA_IDLE_FILL_EN
  logic [SYMBOL_W-1:0] w_comma;
  logic [7:0]          r_fill_cnt;

  assign w_fill  = w_boundary & enable_i & ~r_hold_full;
  assign w_comma = rd_neg_i ? 10'b0011111010 : 10'b1100000101;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_fill_cnt <= 8'd0;
    end else if (w_fill && (r_fill_cnt != 8'hFF)) begin
      r_fill_cnt <= r_fill_cnt + 8'd1;
    end
  end

  assign fill_count_o = r_fill_cnt;
`else
  logic                w_unused_rd_neg;
  logic [SYMBOL_W-1:0] w_comma;

  assign w_unused_rd_neg = rd_neg_i;
  assign w_fill          = 1'b0;
  assign w_comma         = '0;
  assign fill_count_o    = 8'd0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_shift <= '0;
    end else if (w_load) begin
      r_state <= ST_SHIFT;
      r_cnt   <= 4'd0;
      r_shift <= r_hold;
    end else if (w_fill) begin
      r_state <= ST_SHIFT;
      r_cnt   <= 4'd0;
      r_shift <= w_comma;
    end else if (r_state == ST_SHIFT) begin
      if (r_cnt == LAST_BIT) begin
        r_state <= ST_IDLE;
      end else begin
        r_cnt   <= r_cnt + 4'd1;
        r_shift <= {r_shift[SYMBOL_W-2:0], 1'b0};
      end
    end
  end

  // An accept only happens while empty, so it never collides with a load.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_hold_full <= 1'b0;
    end else if (w_accept) begin
      r_hold_full <= 1'b1;
    end else if (w_load) begin
      r_hold_full <= 1'b0;
    end
  end

  // NOTE: the holding data needs no reset; r_hold_full qualifies it, and
  // leaving it out of the reset keeps it a plain enable flop.
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_hold <= symbol_i;
    end
  end

  assign serial_valid_o = (r_state == ST_SHIFT);
  assign serial_o       = serial_valid_o & r_shift[SYMBOL_W-1];
  assign symbol_start_o = serial_valid_o & (r_cnt == 4'd0);

endmodule

// File: tb/tb_tx_serializer_10b.sv
// Directed bench for tx_serializer_10b: per-cycle vector table plus hand-written
// sequences for reset mid-symbol and (when COMMA_IDLE_FILL_EN is defined) comma fill.
module tb_tx_serializer_10b;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       enable_i;
  logic [9:0] symbol_i;
  logic       symbol_valid_i;
  logic       symbol_ready_o;
  logic       rd_neg_i;
  logic       serial_o;
  logic       serial_valid_o;
  logic       symbol_start_o;
  logic [7:0] fill_count_o;

  int checks = 0;
  int errors = 0;

  tx_serializer_10b #(.SYMBOL_W(10)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .enable_i       (enable_i),
    .symbol_i       (symbol_i),
    .symbol_valid_i (symbol_valid_i),
    .symbol_ready_o (symbol_ready_o),
    .rd_neg_i       (rd_neg_i),
    .serial_o       (serial_o),
    .serial_valid_o (serial_valid_o),
    .symbol_start_o (symbol_start_o),
    .fill_count_o   (fill_count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       en;
    logic       vld;
    logic [9:0] sym;
    logic       e_sv;
    logic       e_ser;
    logic       e_start;
    logic       e_rdy;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic void add(input logic en, input logic vld, input logic [9:0] sym,
                              input logic e_sv, input logic e_ser, input logic e_start,
                              input logic e_rdy);
    vec_t v;
    v.en = en; v.vld = vld; v.sym = sym;
    v.e_sv = e_sv; v.e_ser = e_ser; v.e_start = e_start; v.e_rdy = e_rdy;
    tbl.push_back(v);
  endfunction

  // Send one symbol, catch it at bit 5 and assert reset asynchronously.
  task automatic reset_mid_symbol();
    logic found = 1'b0;
    @(negedge clk_i);
    enable_i = 1'b1; symbol_valid_i = 1'b1; symbol_i = 10'b1111111111;
    @(negedge clk_i);
    symbol_valid_i = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk_i);
      if (symbol_start_o) begin
        found = 1'b1;
        break;
      end
    end
    check("rst_wait_start", 32'(found), 32'd1);
    repeat (5) @(negedge clk_i);
    check("rst_cnt5_valid", 32'(serial_valid_o), 32'd1);
    #2 rst_i = 1'b1;
    #1;
    check("rst_async_ser",   32'(serial_o),       32'd0);
    check("rst_async_sv",    32'(serial_valid_o), 32'd0);
    check("rst_async_start", 32'(symbol_start_o), 32'd0);
    check("rst_async_rdy",   32'(symbol_ready_o), 32'd0);
    check("rst_async_fill",  32'(fill_count_o),   32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check("rst_rel_rdy_en1", 32'(symbol_ready_o), 32'd1);
    check("rst_rel_sv",      32'(serial_valid_o), 32'd0);
    enable_i = 1'b0;
    #1;
    check("rst_rel_rdy_en0", 32'(symbol_ready_o), 32'd0);
  endtask

  initial begin
    logic [9:0] s1;
    logic [9:0] sa;
    logic [9:0] sb;
    logic [9:0] ones;
    logic [9:0] k_neg;
    logic [9:0] k_pos;
    s1    = 10'b1001110100;
    sa    = 10'h2AA;
    sb    = 10'h0F3;
    ones  = 10'h3FF;
    k_neg = 10'b0011111010;
    k_pos = 10'b1100000101;

    rst_i = 1'b1; enable_i = 1'b1; symbol_valid_i = 1'b0; symbol_i = '0; rd_neg_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("reset_rdy",   32'(symbol_ready_o), 32'd0);
    check("reset_ser",   32'(serial_o),       32'd0);
    check("reset_sv",    32'(serial_valid_o), 32'd0);
    check("reset_start", 32'(symbol_start_o), 32'd0);
    check("reset_fill",  32'(fill_count_o),   32'd0);
    enable_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;

`ifdef COMMA_IDLE_FILL_EN
    // Idle fill: three negative-disparity commas, then a positive one.
    enable_i = 1'b1; rd_neg_i = 1'b1;
    #1;
    check("fill_idle_sv",   32'(serial_valid_o), 32'd0);
    check("fill_idle_cnt",  32'(fill_count_o),   32'd0);
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 10; i++) begin
        @(negedge clk_i);
        if (k == 2 && i == 9) rd_neg_i = 1'b0;
        check("fill_sv",    32'(serial_valid_o), 32'd1);
        check("fill_ser",   32'(serial_o),       32'((k < 3) ? k_neg[9-i] : k_pos[9-i]));
        check("fill_start", 32'(symbol_start_o), 32'(i == 0));
        check("fill_cnt",   32'(fill_count_o),   32'(k + 1));
      end
    end
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk_i);
      if (fill_count_o == 8'd255) break;
    end
    check("fill_sat_reach", 32'(fill_count_o), 32'd255);
    repeat (25) @(negedge clk_i);
    check("fill_sat_hold", 32'(fill_count_o), 32'd255);
    enable_i = 1'b0;
    repeat (12) @(negedge clk_i);
    check("fill_off_sv", 32'(serial_valid_o), 32'd0);
`else
    // No fill: enabled with nothing to send stays idle.
    enable_i = 1'b1;
    repeat (5) @(negedge clk_i);
    check("nofill_sv",   32'(serial_valid_o), 32'd0);
    check("nofill_fill", 32'(fill_count_o),   32'd0);

    // Single symbol.
    add(1, 1, s1, 0, 0, 0, 1);
    add(1, 0, '0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) add(1, 0, '0, 1, s1[9-i], i == 0, 1);
    add(1, 0, '0, 0, 0, 0, 1);

    // Back-to-back 3FF then 000; ready low while the holding register is full.
    add(1, 1, ones, 0, 0, 0, 1);
    add(1, 1, '0, 0, 0, 0, 0);
    add(1, 1, '0, 1, 1, 1, 1);
    for (int i = 1; i < 10; i++) add(1, 0, '0, 1, 1, 0, 0);
    for (int i = 0; i < 10; i++) add(1, 0, '0, 1, 0, i == 0, 1);
    add(1, 0, '0, 0, 0, 0, 1);

    // Enable dropped at bit 4: finish A, idle holding B, re-enable sends B.
    add(1, 1, sa, 0, 0, 0, 1);
    add(1, 1, sb, 0, 0, 0, 0);
    add(1, 1, sb, 1, sa[9], 1, 1);
    for (int i = 1; i < 4; i++)  add(1, 0, '0, 1, sa[9-i], 0, 0);
    for (int i = 4; i < 10; i++) add(0, 0, '0, 1, sa[9-i], 0, 0);
    add(0, 0, '0, 0, 0, 0, 0);
    add(0, 0, '0, 0, 0, 0, 0);
    add(1, 0, '0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) add(1, 0, '0, 1, sb[9-i], i == 0, 1);
    add(1, 0, '0, 0, 0, 0, 1);

    foreach (tbl[i]) begin
      @(negedge clk_i);
      enable_i = tbl[i].en; symbol_valid_i = tbl[i].vld; symbol_i = tbl[i].sym;
      #1;
      check($sformatf("vec%0d_sv", i),    32'(serial_valid_o), 32'(tbl[i].e_sv));
      check($sformatf("vec%0d_ser", i),   32'(serial_o),       32'(tbl[i].e_ser));
      check($sformatf("vec%0d_start", i), 32'(symbol_start_o), 32'(tbl[i].e_start));
      check($sformatf("vec%0d_rdy", i),   32'(symbol_ready_o), 32'(tbl[i].e_rdy));
    end
    check("vec_fill_zero", 32'(fill_count_o), 32'd0);
`endif

    reset_mid_symbol();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_serializer_10b.md
TX_SERIALIZER_10B -- requirements
Module: tx_serializer_10b

Interface
REQ-001 The block SHALL have one parameter: SYMBOL_W, default 10, the width of the symbol in bits; only the value 10 is supported.
REQ-002 The ports SHALL be, clock and reset first:
- clk_i  input  1  clock.
- rst_i  input  1  reset; asynchronous, active-high.
- enable_i  input  1  permits new symbols to start.
- symbol_i  input  10  8b10b symbol; [9:4]=abcdei from the 5b6b stage, [3:0]=fghj from the 3b4b stage.
- symbol_valid_i  input  1  symbol_i is valid.
- symbol_ready_o  output  1  a symbol is accepted this cycle when symbol_ready_o and symbol_valid_i are both high.
- rd_neg_i  input  1  current running disparity is negative; used only for fill commas.
- serial_o  output  1  serial bit stream.
- serial_valid_o  output  1  serial_o carries a symbol bit.
- symbol_start_o  output  1  high while serial_o carries bit 9 (bit a) of a symbol.
- fill_count_o  output  8  number of inserted fill commas, saturating.

Function
REQ-003 The block SHALL contain a one-entry holding register; symbol_ready_o = enable_i AND holding register empty.
REQ-004 The block SHALL contain a 10-bit shifter, a 4-bit bit counter (0..9) and a state machine with two states:
- IDLE: serial_valid_o=0, serial_o=0.
- SHIFT: serial_valid_o=1.
REQ-005 Bit order SHALL be MSB first: serial_o = symbol bit 9 when the counter is 0, and symbol bit 0 when the counter is 9.
REQ-006 Transition IDLE->SHIFT: at a clock edge where enable_i=1 and a symbol is in the holding register, the block SHALL load the shifter from the holding register, empty the holding register and clear the counter.
REQ-007 Latency: a symbol accepted at edge N into an empty, IDLE block SHALL appear with bit 9 on serial_o in the cycle after edge N+1.
REQ-008 At the edge where the counter is 9 (the last bit):
- If enable_i=1 and the holding register is full, the block SHALL reload the shifter from the holding register and stay in SHIFT, giving gapless back-to-back symbols.
- Otherwise the block SHALL go to IDLE, unless REQ-014 applies.
REQ-009 When the holding register is emptied and a new symbol is accepted at the same edge, the new symbol SHALL be stored, so that no bubble appears on symbol_ready_o.
REQ-010 If enable_i is deasserted in the middle of a symbol, the block SHALL finish that symbol, then go to IDLE and retain the contents of the holding register.
REQ-011 The counter SHALL increment by 1 in SHIFT and wrap from 9 to 0 only on a reload.
REQ-012 symbol_start_o SHALL equal serial_valid_o AND (counter == 0).

Reset
REQ-013 While rst_i is high the block SHALL hold:
- state IDLE, counter 0, shifter 0, holding register empty;
- symbol_ready_o=0, serial_o=0, serial_valid_o=0, symbol_start_o=0, fill_count_o=0.
A symbol in flight when reset asserts SHALL be discarded.

Configuration
REQ-014 With macro COMMA_IDLE_FILL_EN defined:
- At the last-bit edge (or in IDLE), if enable_i=1 and the holding register is empty, the block SHALL load K28.5 into the shifter and enter or stay in SHIFT.
- The comma SHALL be 0011111010 when rd_neg_i=1 and 1100000101 when rd_neg_i=0.
- fill_count_o SHALL increment on each such load and saturate at 255.
REQ-015 Without COMMA_IDLE_FILL_EN:
- No fill SHALL occur; the block idles per REQ-008.
- fill_count_o SHALL be tied to 0.

Verification
REQ-016 A bench SHALL cover the following directed scenarios:
- Single symbol 10'b1001110100 accepted at edge N -> serial_o sequence 1,0,0,1,1,1,0,1,0,0 starting in the cycle after N+1, with symbol_start_o on the first bit only, then serial_valid_o=0.
- Back-to-back symbols 10'h3FF then 10'h000 with valid held high -> 20 contiguous valid bits (ten 1s, then ten 0s) and no gap.
- Valid held high with the holding register full -> symbol_ready_o=0 until the shifter reloads, then 1 in the following cycle.
- enable_i dropped at counter 4 -> the current symbol completes, the block goes to IDLE, the pending symbol is retained; re-enable -> the pending symbol is sent.
- rst_i asserted at counter 5 -> all outputs 0 immediately; after release, IDLE with symbol_ready_o=enable_i.
- With COMMA_IDLE_FILL_EN, no input, rd_neg_i=1 -> 0011111010 repeated and fill_count_o counting 1,2,3...; without the macro -> serial_valid_o=0.
